rpn_stack: RTL and testbench
============================

// Module: rpn_stack
// PURPOSE
//  Operand stack for the RPN calculator. Consumes the push/pop/swap/write
//  command levels and the new_value word from the key-decode stage. Produces
//  top/next operands, the element count and a sticky error flag, which feed
//  back to the decode stage and on to the BCD display.
// PARAMETERS
//  WIDTH    32  data word width (two's complement)
//  DEPTH    32  maximum number of stack entries
//  COUNT_W  6   width of count, $clog2(DEPTH)+1
// PORTS
//  clock  in   1        50 MHz system clock, all state on posedge
//  reset  in   1        asynchronous, active-high; clears all state
//  push   in   1        level: insert 0 above top
//  pop    in   1        level: remove top (combined with write = binary op)
//  swap   in   1        level: exchange top and next
//  write  in   1        level: overwrite top with value
//  value  in   WIDTH    data for write, sampled in the same cycle as write edge
//  top    out  WIDTH    entry count-1
//  next   out  WIDTH    entry count-2; 0 when count<2
//  count  out  COUNT_W  number of valid entries, 1..DEPTH
//  error  out  1        sticky stack-fault flag
// BEHAVIOUR
//  - Reset (async): count=1, entry0=0, top=0, next=0, error=0. Edge-detect
//    history regs =1, so commands held through reset release do not fire.
//  - Commands are edge-triggered. A command acts once, in the cycle where its
//    level is 1 and its registered previous value is 0. Holding a key never
//    repeats it. Each edge is called an "event" below.
//  - Latency: top/next/count/error reflect an event on the next posedge (1 cycle).
//  - Event priority when several rise in one cycle:
//    push > swap > pop+write > pop > write. Lower-priority edges are consumed
//    and discarded. Exception: pop+write together form the binary-op event.
//  - push: count==DEPTH -> error=1, no change. Else entry[count]=0, count+1.
//  - swap: count<2 -> error=1. Else exchange entry[count-1] and entry[count-2].
//  - pop alone: count==1 -> error=1. Else count-1.
//  - pop+write (binary op): count<2 -> error=1, no change.
//    Else entry[count-2]=value, count-1.
//  - write alone: entry[count-1]=value. Always legal.
//  - When error=1, all events are ignored and state is frozen until reset.
//  - Entries at or above count are don't-care. They never reach top or next.
//  - No arithmetic is done here. Values are stored verbatim, WIDTH bits.
//  - Storage is a DEPTH x WIDTH register array with one write port per cycle.
//    top/next are registered copies updated with the event.
// TESTING
//  1 reset; write value=7 -> next cycle top=7, next=0, count=1, error=0.
//  2 write 5, push, write 3, pop+write value=8 -> top=8, count=1.
//  3 stack [5,3] (top 3), swap -> top=5, next=3, count=2.
//    Hold swap 10 cycles -> exactly one swap.
//  4 count=1, pop -> error=1, count=1.
//    Later push is ignored; reset -> error=0, count=1, top=0.
//  5 32 push events (count 1->32 after 31); 32nd push -> error=1, count=32.
//  6 push and pop rise in the same cycle with count=1 -> push wins:
//    count=2, top=0, error=0.
//    Reset asserted mid-hold of write -> no write after release.

Source files
------------

// File: rtl/rpn_stack.sv
// Operand stack for the RPN calculator: edge-triggered push/pop/swap/write commands,
// registered top/next copies, and a sticky fault flag that freezes state until reset.
module rpn_stack #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned DEPTH   = 32,
    parameter int unsigned COUNT_W = 6
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic               swap,
    input  logic               write,
    input  logic [WIDTH-1:0]   value,
    output logic [WIDTH-1:0]   top,
    output logic [WIDTH-1:0]   next,
    output logic [COUNT_W-1:0] count,
    output logic               error
);

    localparam int unsigned AW = $clog2(DEPTH);

    // The two upper entries live in top_q/next_q; mem[i] holds entry i for i < count-2,
    // so every event needs at most one array write and swap touches no array entry.
    logic [WIDTH-1:0]   mem [DEPTH];
    logic [WIDTH-1:0]   top_q, top_d;
    logic [WIDTH-1:0]   next_q, next_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               error_q, error_d;
    logic               push_q, pop_q, swap_q, write_q;

    logic               push_ev, pop_ev, swap_ev, write_ev;
    logic               mem_we;
    logic [AW-1:0]      wr_idx;
    logic [AW-1:0]      rd_idx;
    logic [WIDTH-1:0]   below_next;

    assign push_ev  = push  & ~push_q;
    assign pop_ev   = pop   & ~pop_q;
    assign swap_ev  = swap  & ~swap_q;
    assign write_ev = write & ~write_q;

    // Modulo-2^AW index arithmetic stays correct even when count == DEPTH.
    assign wr_idx     = count_q[AW-1:0] - AW'(2);
    assign rd_idx     = count_q[AW-1:0] - AW'(3);
    assign below_next = (count_q >= COUNT_W'(3)) ? mem[rd_idx] : '0;

    always_comb begin
        top_d   = top_q;
        next_d  = next_q;
        count_d = count_q;
        error_d = error_q;
        mem_we  = 1'b0;
        if (!error_q) begin
            if (push_ev) begin
                if (count_q == COUNT_W'(DEPTH)) begin
                    error_d = 1'b1;
                end else begin
                    mem_we  = (count_q >= COUNT_W'(2));
                    next_d  = top_q;
                    top_d   = '0;
                    count_d = count_q + COUNT_W'(1);
                end
            end else if (swap_ev) begin
                if (count_q < COUNT_W'(2)) begin
                    error_d = 1'b1;
                end else begin
                    top_d  = next_q;
                    next_d = top_q;
                end
            end else if (pop_ev && write_ev) begin
                if (count_q < COUNT_W'(2)) begin
                    error_d = 1'b1;
                end else begin
                    top_d   = value;
                    next_d  = below_next;
                    count_d = count_q - COUNT_W'(1);
                end
            end else if (pop_ev) begin
                if (count_q == COUNT_W'(1)) begin
                    error_d = 1'b1;
                end else begin
                    top_d   = next_q;
                    next_d  = below_next;
                    count_d = count_q - COUNT_W'(1);
                end
            end else if (write_ev) begin
                top_d = value;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            top_q   <= '0;
            next_q  <= '0;
            count_q <= COUNT_W'(1);
            error_q <= 1'b0;
            // History starts high so levels held through reset release do not fire.
            push_q  <= 1'b1;
            pop_q   <= 1'b1;
            swap_q  <= 1'b1;
            write_q <= 1'b1;
        end else begin
            top_q   <= top_d;
            next_q  <= next_d;
            count_q <= count_d;
            error_q <= error_d;
            push_q  <= push;
            pop_q   <= pop;
            swap_q  <= swap;
            write_q <= write;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[wr_idx] <= next_q;
        end
    end

    assign top   = top_q;
    assign next  = next_q;
    assign count = count_q;
    assign error = error_q;

endmodule

// File: tb/tb_rpn_stack.sv
// Directed bench for rpn_stack: hand-computed expectations checked with immediate assertions.
module tb_rpn_stack;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        push  = 1'b0;
    logic        pop   = 1'b0;
    logic        swap  = 1'b0;
    logic        write = 1'b0;
    logic [31:0] value = '0;
    logic [31:0] top;
    logic [31:0] next;
    logic [5:0]  count;
    logic        error;

    int checks = 0;
    int errors = 0;

    rpn_stack #(
        .WIDTH  (32),
        .DEPTH  (32),
        .COUNT_W(6)
    ) dut (
        .clock(clock),
        .reset(reset),
        .push (push),
        .pop  (pop),
        .swap (swap),
        .write(write),
        .value(value),
        .top  (top),
        .next (next),
        .count(count),
        .error(error)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic state(input string tag, input logic [31:0] t, input logic [31:0] n,
                         input logic [5:0] c, input logic e);
        chk({tag, ".top"}, top, t);
        chk({tag, ".next"}, next, n);
        chk({tag, ".count"}, 32'(count), 32'(c));
        chk({tag, ".error"}, 32'(error), 32'(e));
    endtask

    // Raise the given levels for one cycle, then drop them for one cycle.
    task automatic press(input logic pu, input logic po, input logic sw, input logic wr,
                         input logic [31:0] v);
        push = pu; pop = po; swap = sw; write = wr; value = v;
        tick();
        push = 0; pop = 0; swap = 0; write = 0;
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        // 1: reset values, then a single write
        tick();
        reset = 1'b0;
        tick();
        state("rst", 0, 0, 1, 0);
        press(0, 0, 0, 1, 7);
        state("wr7", 7, 0, 1, 0);

        // 2: binary op collapses two entries into value
        press(0, 0, 0, 1, 5);
        press(1, 0, 0, 0, 0);
        state("push1", 0, 5, 2, 0);
        press(0, 0, 0, 1, 3);
        state("wr3", 3, 5, 2, 0);
        press(0, 1, 0, 1, 8);
        state("binop", 8, 0, 1, 0);

        // 3: swap, and holding swap acts once
        press(0, 0, 0, 1, 5);
        press(1, 0, 0, 0, 0);
        press(0, 0, 0, 1, 3);
        press(0, 0, 1, 0, 0);
        state("swap", 5, 3, 2, 0);
        swap = 1'b1;
        repeat (10) tick();
        swap = 1'b0;
        tick();
        state("swaphold", 3, 5, 2, 0);
        // Deeper entries round-trip through the array
        press(1, 0, 0, 0, 0);
        press(0, 0, 0, 1, 9);
        press(1, 0, 0, 0, 0);
        state("deep", 0, 9, 4, 0);
        press(0, 1, 0, 0, 0);
        state("pop4", 9, 3, 3, 0);
        press(0, 1, 0, 0, 0);
        state("pop3", 3, 5, 2, 0);

        // 4: underflow is sticky until reset
        do_reset();
        press(0, 1, 0, 0, 0);
        state("under", 0, 0, 1, 1);
        press(1, 0, 0, 0, 0);
        state("frozen", 0, 0, 1, 1);
        do_reset();
        state("clear", 0, 0, 1, 0);

        // 5: fill to DEPTH, then overflow
        for (int i = 1; i <= 31; i++) begin
            press(1, 0, 0, 0, 0);
            press(0, 0, 0, 1, 32'(i));
        end
        state("full", 31, 30, 32, 0);
        press(0, 1, 0, 0, 0);
        state("popfull", 30, 29, 31, 0);
        press(1, 0, 0, 0, 0);
        state("refill", 0, 30, 32, 0);
        press(1, 0, 0, 0, 0);
        state("over", 0, 30, 32, 1);

        // 6: push beats pop in the same cycle
        do_reset();
        press(1, 1, 0, 0, 0);
        state("prio", 0, 0, 2, 0);

        // Write held across reset does not fire on release
        do_reset();
        write = 1'b1;
        value = 32'd9;
        tick();
        chk("wrhold.pre", top, 32'd9);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (3) tick();
        write = 1'b0;
        tick();
        state("wrhold", 0, 0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
